seq_det_ctrl: RTL
=================

Name: seq_det_ctrl

Overview:
Programmable serial pattern-detector controller for the FSM library.
- Holds a configurable pattern of 1..MAXLEN bits, an overlap/non-overlap mode and a match target.
- Sequences a detection run over a qualified serial bit stream (x/x_valid), counts matches and signals completion.
- Generalises the fixed Moore sequence detectors (e.g. 1001 overlap) into one configurable, start/abort-controlled block.

Parameters:
MAXLEN, 8, maximum pattern length in bits (>=2)
LENW, $clog2(MAXLEN)+1, width of the length field
CNTW, 8, width of the match counter and target

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-high reset
cfg_valid  input  1  configuration offer
cfg_ready  output  1  configuration can be accepted (high in IDLE or DONE)
cfg_pattern  input  MAXLEN  pattern; bit [len-1] is first-received bit, bit [0] last-received
cfg_len  input  LENW  pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CNTW  matches before DONE; 0 = run until abort
cfg_err  output  1  one-cycle pulse: accepted config had an illegal length
start  input  1  begin run (pulse)
abort  input  1  terminate run (pulse)
x  input  1  serial data bit
x_valid  input  1  x qualifier
busy  output  1  high in RUN
match  output  1  registered one-cycle pulse per detected pattern
match_count  output  CNTW  matches in current/last run
done  output  1  high while in DONE

Behaviour:
- All state changes on rising clk. Reset is synchronous: clear high at an edge overrides everything.
- Reset values:
  - state=IDLE; busy=0, match=0, done=0, cfg_err=0, match_count=0, history=0, fill=0.
  - Stored config: pattern=...0001001 (4'b1001, upper bits 0), len=4, overlap=1, target=0.
- States:
  - IDLE: start -> RUN, clearing match_count, history and fill.
  - RUN:
    - abort -> IDLE.
    - Count reaching nonzero target -> DONE.
    - start ignored.
  - DONE:
    - start -> RUN, clearing count/history/fill.
    - abort -> IDLE.
  - abort has priority over start in the same cycle.
- Configuration handshake:
  - cfg_ready = (state==IDLE || state==DONE).
  - Transfer occurs at an edge where cfg_valid && cfg_ready.
  - Legal cfg_len (1..MAXLEN): all four fields loaded.
  - Illegal cfg_len (0 or >MAXLEN): nothing loaded; cfg_err=1 next cycle for exactly one cycle.
  - Config and start in the same cycle: new config is used by the run being started.
- Detection, only in RUN at edges with x_valid=1:
  - history <= {history[MAXLEN-2:0], x}.
  - fill <= min(fill+1, MAXLEN).
  - Let h' and f' be the updated history and fill. Hit when f' >= len and h'[len-1:0] == pattern[len-1:0].
  - On hit: match=1 in the following cycle only; match_count increments, saturating at all-ones.
  - Overlap=1: history and fill retained after a hit.
  - Overlap=0: fill<=0 on hit, so the next hit needs len fresh bits.
  - x_valid=0: history, fill and match_count hold; match=0.
- Latency: match is asserted the cycle after the edge that samples the final pattern bit.
  - The DONE transition (done=1, busy=0) occurs at that same edge, so match and done rise together.
- match_count holds its value in DONE and IDLE until the next start. Bits outside IDLE/RUN samples are ignored.
- clear or abort mid-run: no further match pulses. A match already registered still completes its one-cycle pulse unless clear is asserted.

Test Plan:
- Reset defaults, overlap, target 0: start; stream 1,0,0,1,0,0,1 (x_valid=1) -> match pulses after bits 4 and 7; match_count=2; busy stays 1; done=0.
- Non-overlap: load pattern 1001, len 4, overlap 0; same stream -> single match after bit 4; match_count=1.
- Target stop: target=2, overlap=1; stream 1001001 -> done=1 and busy=0 in the cycle match pulses for bit 7; later bits ignored; count stays 2; start restarts with count 0.
- Gapped input: pattern 101, len 3; bits 1,0,1 with x_valid low 3 cycles between each -> exactly one match after the third valid bit; no match during gaps.
- Config rules:
  - cfg_len=0 in IDLE -> cfg_err pulses once; default 1001 still detected.
  - cfg_valid during RUN -> cfg_ready=0, config unchanged.
  - len=MAXLEN all-ones pattern detected after MAXLEN ones.
- Abort/clear: abort and start together in RUN -> IDLE; clear mid-pattern -> all outputs at reset values next cycle, and the pattern completed after clear is not matched unless start is issued.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: configurable pattern/length/overlap/target, start/abort run control.
// Latency: match pulse and DONE entry one cycle after the edge that samples the last pattern bit.
// Backpressure: none on x; config accepted only in IDLE/DONE (cfg_ready low while a run is active).
module seq_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int LENW   = $clog2(MAXLEN) + 1,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    input  logic              x,
    input  logic              x_valid,
    output logic              busy,
    output logic              match,
    output logic [CNTW-1:0]   match_count,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reset-time configuration reproduces the classic 1001 overlapping detector.
    localparam logic [MAXLEN-1:0] DEF_PATTERN = MAXLEN'(4'b1001);
    localparam logic [LENW-1:0]   DEF_LEN     = LENW'(4);
    localparam logic [LENW-1:0]   MAX_LEN_V   = LENW'(MAXLEN);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              match_q;
    logic              cfg_err_q;
    logic [CNTW-1:0]   cnt_q;
    logic [MAXLEN-1:0] hist_q;
    logic [LENW-1:0]   fill_q;

    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic              ovl_q;
    logic [CNTW-1:0]   tgt_q;

    logic [MAXLEN-1:0] hist_d;
    logic [LENW-1:0]   fill_d;
    logic [CNTW-1:0]   cnt_d;
    logic [MAXLEN-1:0] len_mask;
    logic              hit;
    logic              cfg_xfer;
    logic              cfg_len_ok;
    logic              target_hit;

    assign cfg_ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cfg_xfer    = cfg_valid && cfg_ready;
    assign cfg_len_ok  = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);

    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q;
    assign cfg_err     = cfg_err_q;
    assign match_count = cnt_q;

    // Candidate next history/fill/count for a valid bit and the hit decision on the updated history.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            len_mask[i] = (LENW'(i) < len_q);
        end
        hist_d     = {hist_q[MAXLEN-2:0], x};
        fill_d     = (fill_q >= MAX_LEN_V) ? MAX_LEN_V : fill_q + 1'b1;
        hit        = (fill_d >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        target_hit = (tgt_q != '0) && (cnt_d == tgt_q);
    end

    // Control FSM, configuration registers, detection datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= DEF_PATTERN;
            len_q     <= DEF_LEN;
            ovl_q     <= 1'b1;
            tgt_q     <= '0;
        end else begin
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;

            // A config offered alongside start lands at the same edge, so the new run uses it.
            if (cfg_xfer) begin
                if (cfg_len_ok) begin
                    pat_q <= cfg_pattern;
                    len_q <= cfg_len;
                    ovl_q <= cfg_overlap;
                    tgt_q <= cfg_target;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        hist_q  <= '0;
                        fill_q  <= '0;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        // Abort wins over any bit sampled this cycle: no further match pulses.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (x_valid) begin
                        hist_q <= hist_d;
                        if (hit) begin
                            match_q <= 1'b1;
                            cnt_q   <= cnt_d;
                            // Non-overlap mode forces len fresh bits before the next hit.
                            fill_q  <= ovl_q ? fill_d : '0;
                            if (target_hit) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            fill_q <= fill_d;
                        end
                    end
                end

                S_DONE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end else if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        hist_q  <= '0;
                        fill_q  <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
